// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- MEM-stage data-memory engine.
//
// Consumes the EX/MEM register outputs. Loads and stores go out on an SRAM-like
// request/response bus. data_stall freezes EX/MEM while an access is in flight.
// Load data is aligned and extended, store data is replicated across byte lanes,
// and misaligned halfword/word addresses are reported as ADEL/ADES faults.
//
// Build option:
//   MEM_ADDR_CHECK_EN  defined   : misaligned H/W accesses fault (ADEL/ADES),
//                                  no bus request is issued and bad_vaddr is set.
//                      undefined : no faults; the low address bits of H/W
//                                  accesses are forced to zero instead.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   exception                 pipeline flush
//   mem_aluop                 memory opcode from EX/MEM
//   mem_mem_to_reg            instruction is a load
//   mem_ram_write_enable      instruction is a store
//   mem_alu_data              effective address, or ALU result for other ops
//   mem_ram_write_data        store source value
//   mem_exception_type        incoming exception vector
//   data_req/wr/size/addr/wdata   bus request channel
//   data_addr_ok              request accepted by the slave
//   data_data_ok, data_rdata  response valid (read data / write done)
//   data_stall                stall request to the pipeline
//   wb_data                   value for MEM/WB
//   exception_type_o          incoming vector plus ADEL/ADES
//   bad_vaddr                 faulting address, 0 when there is no fault
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int ADEL_BIT = 4,
    parameter int ADES_BIT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic [7:0]  mem_aluop,
    input  logic        mem_mem_to_reg,
    input  logic        mem_ram_write_enable,
    input  logic [31:0] mem_alu_data,
    input  logic [31:0] mem_ram_write_data,
    input  logic [31:0] mem_exception_type,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        data_stall,
    output logic [31:0] wb_data,
    output logic [31:0] exception_type_o,
    output logic [31:0] bad_vaddr
);

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LBU = 8'h21;
    localparam logic [7:0] OP_LH  = 8'h22;
    localparam logic [7:0] OP_LHU = 8'h23;
    localparam logic [7:0] OP_LW  = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2A;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    state_t      state, state_next;
    logic [31:0] rdata_q;
    logic        capture;
    logic        req_c, stall_c;

    logic        is_load, is_store, is_signed;
    logic [1:0]  size;
    logic        addr_err;
    logic        access;
    logic [31:0] eff_addr;
    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_aligned;

    // ------------------------------------------------------------------ decode
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SIZE_W;
        case (mem_aluop)
            OP_LB:  begin is_load  = 1'b1; size = SIZE_B; is_signed = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; size = SIZE_B; end
            OP_LH:  begin is_load  = 1'b1; size = SIZE_H; is_signed = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; size = SIZE_H; end
            OP_LW:  begin is_load  = 1'b1; size = SIZE_W; end
            OP_SB:  begin is_store = 1'b1; size = SIZE_B; end
            OP_SH:  begin is_store = 1'b1; size = SIZE_H; end
            OP_SW:  begin is_store = 1'b1; size = SIZE_W; end
            default: ;
        endcase
        // The EX/MEM control flags qualify the opcode: a bubble whose opcode
        // field is stale must not touch memory.
        is_load  = is_load  & mem_mem_to_reg;
        is_store = is_store & mem_ram_write_enable;
    end

    // ------------------------------------------------------- address handling
`ifdef MEM_ADDR_CHECK_EN
    assign addr_err = (is_load || is_store) &&
                      (((size == SIZE_H) && mem_alu_data[0]) ||
                       ((size == SIZE_W) && (mem_alu_data[1:0] != 2'b00)));
    assign eff_addr = mem_alu_data;
`else
    assign addr_err = 1'b0;
    // Without checking, misaligned H/W addresses are silently rounded down.
    always_comb begin
        eff_addr = mem_alu_data;
        if (size == SIZE_H) eff_addr[0]   = 1'b0;
        if (size == SIZE_W) eff_addr[1:0] = 2'b00;
    end
`endif

    assign access    = (is_load || is_store) && !addr_err && !exception;
    assign bad_vaddr = addr_err ? mem_alu_data : 32'd0;

    always_comb begin
        exception_type_o = mem_exception_type;
        if (addr_err && is_load)  exception_type_o[ADEL_BIT] = 1'b1;
        if (addr_err && is_store) exception_type_o[ADES_BIT] = 1'b1;
    end

    // ------------------------------------------------------------ bus fields
    assign data_wr   = is_store;
    assign data_size = size;
    assign data_addr = eff_addr;

    always_comb begin
        case (size)
            SIZE_B:  data_wdata = {4{mem_ram_write_data[7:0]}};
            SIZE_H:  data_wdata = {2{mem_ram_write_data[15:0]}};
            default: data_wdata = mem_ram_write_data;
        endcase
    end

    // ----------------------------------------------------------- load align
    assign shifted  = data_rdata >> {eff_addr[1:0], 3'b000};
    assign sel_byte = shifted[7:0];
    assign sel_half = eff_addr[1] ? data_rdata[31:16] : data_rdata[15:0];

    always_comb begin
        case (size)
            SIZE_B:  load_aligned = is_signed ? {{24{sel_byte[7]}}, sel_byte}
                                              : {24'd0, sel_byte};
            SIZE_H:  load_aligned = is_signed ? {{16{sel_half[15]}}, sel_half}
                                              : {16'd0, sel_half};
            default: load_aligned = data_rdata;
        endcase
    end

    // ------------------------------------------------------------------- FSM
    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (data_addr_ok && data_data_ok) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end else if (data_addr_ok) begin
                        state_next = WAIT;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (exception) begin
                    // Request never accepted, so it can simply be withdrawn.
                    state_next = IDLE;
                end else begin
                    req_c = 1'b1;
                    if (data_addr_ok) begin
                        if (data_data_ok) begin
                            capture    = 1'b1;
                            state_next = DONE;
                        end else begin
                            state_next = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (exception) begin
                    // The accepted request still owes a response; drain it
                    // unless it arrives right now, in which case drop it.
                    state_next = data_data_ok ? IDLE : DRAIN;
                end else if (data_data_ok) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            DRAIN: begin
                // Hold a newly presented access until the stale response
                // clears, keeping the one-outstanding-request rule.
                stall_c = access;
                if (data_data_ok) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs go quiet the moment reset asserts, not at the next edge.
    assign data_req   = rst && req_c;
    assign data_stall = rst && stall_c;

    assign wb_data = ((state == DONE) && is_load) ? rdata_q : mem_alu_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rdata_q <= 32'd0;
        end else begin
            state <= state_next;
            if (capture) rdata_q <= load_aligned;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access -- self-checking bench for mem_access.
// Expected write-back values are queued when an access is driven and popped
// when the DUT drops data_stall (the DONE cycle). Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception;
    logic [7:0]  mem_aluop;
    logic        mem_mem_to_reg;
    logic        mem_ram_write_enable;
    logic [31:0] mem_alu_data;
    logic [31:0] mem_ram_write_data;
    logic [31:0] mem_exception_type;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        data_stall;
    logic [31:0] wb_data;
    logic [31:0] exception_type_o;
    logic [31:0] bad_vaddr;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] sb[$];

    mem_access dut (
        .clk                  (clk),
        .rst                  (rst),
        .exception            (exception),
        .mem_aluop            (mem_aluop),
        .mem_mem_to_reg       (mem_mem_to_reg),
        .mem_ram_write_enable (mem_ram_write_enable),
        .mem_alu_data         (mem_alu_data),
        .mem_ram_write_data   (mem_ram_write_data),
        .mem_exception_type   (mem_exception_type),
        .data_req             (data_req),
        .data_wr              (data_wr),
        .data_size            (data_size),
        .data_addr            (data_addr),
        .data_wdata           (data_wdata),
        .data_addr_ok         (data_addr_ok),
        .data_data_ok         (data_data_ok),
        .data_rdata           (data_rdata),
        .data_stall           (data_stall),
        .wb_data              (wb_data),
        .exception_type_o     (exception_type_o),
        .bad_vaddr            (bad_vaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdat);
        mem_aluop            = op;
        mem_mem_to_reg       = (op >= 8'h20) && (op <= 8'h24);
        mem_ram_write_enable = (op >= 8'h28) && (op <= 8'h2A);
        mem_alu_data         = addr;
        mem_ram_write_data   = wdat;
    endtask

    task automatic set_nop();
        set_op(8'h00, 32'd0, 32'd0);
    endtask

    // Drive one access starting in IDLE. Cycle 0 is the first cycle the access
    // is presented; addr_ok pulses in cycle ao and data_ok in cycle dk.
    // DONE (stall low) is expected in cycle dk+1.
    task automatic do_access(input string name, input logic [7:0] op,
                             input logic [31:0] addr, input logic [31:0] wdat,
                             input logic [31:0] rdat, input int ao, input int dk,
                             input logic [31:0] exp_addr, input logic [1:0] exp_size,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        logic done;
        logic [31:0] exp_v;
        done = 1'b0;
        sb.push_back(exp_wb);
        set_op(op, addr, wdat);
        for (int c = 0; c <= dk + 3 && !done; c++) begin
            data_addr_ok = (c == ao);
            data_data_ok = (c == dk);
            data_rdata   = (c == dk) ? rdat : 32'h0;
            @(negedge clk);
            if (c == 0) begin
                check({name, " addr"},  data_addr, exp_addr);
                check({name, " size"},  32'(data_size), 32'(exp_size));
                check({name, " wr"},    32'(data_wr), 32'(mem_ram_write_enable));
                check({name, " wdata"}, data_wdata, exp_wdata);
                check({name, " excp"},  exception_type_o, mem_exception_type);
                check({name, " badva"}, bad_vaddr, 32'd0);
            end
            if (!data_stall) begin
                exp_v = sb.pop_front();
                check({name, " done_cycle"}, 32'(c), 32'(dk + 1));
                check({name, " wb"}, wb_data, exp_v);
                done = 1'b1;
            end else begin
                check({name, " req"}, 32'(data_req), 32'(c <= ao));
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            check({name, " timeout"}, 32'(done), 32'd1);
            void'(sb.pop_front());
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        set_nop();
    endtask

    initial begin
        rst                = 1'b0;
        exception          = 1'b0;
        mem_exception_type = 32'd0;
        data_addr_ok       = 1'b0;
        data_data_ok       = 1'b0;
        data_rdata         = 32'd0;
        set_nop();

        // ---- reset state
        repeat (2) @(negedge clk);
        check("rst req",   32'(data_req), 32'd0);
        check("rst stall", 32'(data_stall), 32'd0);
        check("rst wb",    wb_data, 32'd0);
        check("rst badva", bad_vaddr, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // ---- loads, stores, alignment and extension
        do_access("lw",  8'h24, 32'h1000, 32'h0, 32'hDEADBEEF, 2, 4,
                  32'h1000, 2'd2, 32'h0, 32'hDEADBEEF);
        do_access("lb",  8'h20, 32'h1003, 32'h0, 32'h80FFFF7F, 0, 1,
                  32'h1003, 2'd0, 32'h0, 32'hFFFFFF80);
        do_access("lbu", 8'h21, 32'h1003, 32'h0, 32'h80FFFF7F, 1, 2,
                  32'h1003, 2'd0, 32'h0, 32'h00000080);
        do_access("lh",  8'h22, 32'h1002, 32'h0, 32'h80FFFF7F, 0, 0,
                  32'h1002, 2'd1, 32'h0, 32'hFFFF80FF);
        do_access("lhu", 8'h23, 32'h1000, 32'h0, 32'h1234F00D, 1, 1,
                  32'h1000, 2'd1, 32'h0, 32'h0000F00D);
        do_access("sh",  8'h29, 32'h2002, 32'h1234ABCD, 32'h0, 0, 0,
                  32'h2002, 2'd1, 32'hABCDABCD, 32'h2002);
        do_access("sb",  8'h28, 32'h2001, 32'h000000A5, 32'h0, 1, 3,
                  32'h2001, 2'd0, 32'hA5A5A5A5, 32'h2001);
        do_access("sw",  8'h2A, 32'h2004, 32'hCAFEBABE, 32'h0, 0, 2,
                  32'h2004, 2'd2, 32'hCAFEBABE, 32'h2004);

        // ---- misaligned addresses
`ifdef MEM_ADDR_CHECK_EN
        set_op(8'h24, 32'h1001, 32'h0);
        @(negedge clk);
        check("adel req",   32'(data_req), 32'd0);
        check("adel stall", 32'(data_stall), 32'd0);
        check("adel excp",  exception_type_o, 32'h10);
        check("adel badva", bad_vaddr, 32'h1001);
        @(posedge clk); #1;
        set_op(8'h2A, 32'h2003, 32'h0);
        @(negedge clk);
        check("ades req",   32'(data_req), 32'd0);
        check("ades excp",  exception_type_o, 32'h20);
        check("ades badva", bad_vaddr, 32'h2003);
        @(posedge clk); #1;
        set_nop();
`else
        do_access("lw_mis", 8'h24, 32'h1001, 32'h0, 32'hCAFEF00D, 0, 1,
                  32'h1000, 2'd2, 32'h0, 32'hCAFEF00D);
        do_access("lh_mis", 8'h22, 32'h1003, 32'h0, 32'h80FFFF7F, 1, 1,
                  32'h1002, 2'd1, 32'h0, 32'hFFFF80FF);
`endif

        // ---- exception in WAIT, drain, then a held access
        set_op(8'h24, 32'h3000, 32'h0);
        data_addr_ok = 1'b1;
        @(negedge clk);
        check("flush req0", 32'(data_req), 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        exception    = 1'b1;
        @(negedge clk);
        check("flush wait stall", 32'(data_stall), 32'd1);
        check("flush wait req",   32'(data_req), 32'd0);
        @(posedge clk); #1;
        exception = 1'b0;
        set_op(8'h24, 32'h4000, 32'h0);
        @(negedge clk);
        check("drain req",   32'(data_req), 32'd0);
        check("drain stall", 32'(data_stall), 32'd1);
        @(posedge clk); #1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0BAD0;
        @(negedge clk);
        check("drain ok req",   32'(data_req), 32'd0);
        check("drain ok stall", 32'(data_stall), 32'd1);
        check("drain ok wb",    wb_data, 32'h4000);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        do_access("after_drain", 8'h24, 32'h4000, 32'h0, 32'h0BADF00D, 1, 2,
                  32'h4000, 2'd2, 32'h0, 32'h0BADF00D);

        // ---- non-memory op
        set_op(8'h01, 32'h55, 32'h0);
        mem_exception_type = 32'h100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("nop wb",    wb_data, 32'h55);
            check("nop req",   32'(data_req), 32'd0);
            check("nop stall", 32'(data_stall), 32'd0);
            check("nop excp",  exception_type_o, 32'h100);
            @(posedge clk); #1;
        end
        mem_exception_type = 32'd0;

        // ---- reset asserted during REQ
        set_op(8'h24, 32'h5000, 32'h0);
        @(negedge clk);
        check("rreq c0 req", 32'(data_req), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rreq c1 req", 32'(data_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rreq rst req",   32'(data_req), 32'd0);
        check("rreq rst stall", 32'(data_stall), 32'd0);
        @(posedge clk); #1;
        set_nop();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        do_access("post_rst", 8'h24, 32'h6000, 32'h0, 32'h01234567, 0, 0,
                  32'h6000, 2'd2, 32'h0, 32'h01234567);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
